data_compare_tracker: RTL and testbench
=======================================

Name: data_compare_tracker

Overview:
- Streaming controller wrapped around the 8-bit data comparator.
- Registers each accepted sample and presents the current/previous pair to the comparator's a/b inputs.
- Consumes the comparator's 3-bit result the following cycle to maintain trend state, run length, running max/min and a sample count.
- Sits between the sample source and downstream status logic; throughput one sample per clock.

Parameters:
- RUN_W, 8, width of run-length counter (saturating)
- CNT_W, 16, width of accepted-sample counter (saturating)

Ports:
- iClk  input  1  system clock, all state on rising edge
- iRst_n  input  1  synchronous active-low reset
- iValid  input  1  sample strobe; sample accepted on any edge with iValid=1
- iSample  input  8  unsigned sample
- oCmp_a  output  8  to comparator a input: current sample register
- oCmp_b  output  8  to comparator b input: previous sample register
- iCmp  input  3  comparator result, one-hot: [2]=a>b, [1]=a==b, [0]=a<b; combinational from oCmp_a/oCmp_b
- oTrend  output  2  00=FLAT, 01=UP, 10=DOWN, 11 unused
- oRunLen  output  RUN_W  consecutive comparisons with the current oTrend
- oRunDone  output  1  one-cycle pulse when a run ends (trend changes)
- oMax  output  8  running maximum of accepted samples
- oMin  output  8  running minimum of accepted samples
- oCount  output  CNT_W  accepted samples, saturating
- oErr  output  1  sticky illegal-comparator-code flag (see Optional Feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (iRst_n=0 at an edge):
  - oCmp_a, oCmp_b, oRunLen, oCount, oErr = 0; oTrend = FLAT; oRunDone = 0; oMax = 8'h00; oMin = 8'hFF.
  - FSM to EMPTY; pending flag cleared.
  - Reset mid-stream discards the in-flight comparison.
- FSM:
  - EMPTY: on iValid, cur<=iSample, oMax<=oMin<=iSample, go FIRST.
  - FIRST: on iValid, prev<=cur, cur<=iSample, pend<=1, go TRACK.
  - TRACK: on iValid, prev<=cur, cur<=iSample, pend<=1. Without iValid, pend<=0.
  - No exit from TRACK except reset.
- Max/min:
  - Updated on the accept edge using an internal compare of iSample vs oMax/oMin.
  - No comparator round-trip; latency 1.
- Comparison latency: pair registered at edge t; iCmp sampled at edge t+1 when pend=1. Trend and run outputs are valid after edge t+1.
- Back-to-back iValid: edge t+1 both evaluates pair k and shifts in sample k+1. iCmp must reflect the pre-edge registers. Throughput 1/cycle.
- Evaluation when pend=1:
  - New direction d: a>b gives UP, a<b gives DOWN, a==b gives FLAT.
  - If d == oTrend and oRunLen != 0: oRunLen += 1, saturating at 2^RUN_W-1.
  - Else: oTrend<=d, oRunLen<=1. oRunDone<=1 if the old oRunLen != 0; otherwise 0.
  - The first evaluation after reset therefore produces no oRunDone.
- oRunDone is high for exactly one cycle per trend change. It is 0 whenever pend=0.
- oCount increments on every accepted sample in every state and saturates at 2^CNT_W-1.
- oCmp_a/oCmp_b hold their value while idle; the comparator output stays stable but is ignored when pend=0.

Optional Feature:
- Macro CMP_CHECK_EN.
- Defined: at evaluation, iCmp not exactly one-hot sets oErr=1, sticky until reset. The trend/run state is left unchanged for that evaluation and oRunDone=0.
- Undefined: oErr tied 0. Non-one-hot codes are treated as equal (FLAT).

Test Plan:
- Reset then samples 10,20,30 on consecutive cycles -> after last evaluation oTrend=01, oRunLen=2, oRunDone never asserted, oMax=30, oMin=10, oCount=3.
- Samples 50,40,40,60 back-to-back -> trend sequence DOWN(1), FLAT(1), UP(1); oRunDone pulses once at the FLAT edge and once at the UP edge; oMin=40, oMax=60.
- Single sample 8'h80 then idle 5 cycles -> FSM in FIRST, oRunLen=0, oTrend=FLAT, oCount=1, oMax=oMin=8'h80.
- RUN_W=2; samples 1,2,3,4,5,6 -> oRunLen saturates at 3 with oTrend=UP and no oRunDone.
- Reset asserted the cycle after a pair is registered -> no evaluation occurs; all outputs at reset values next cycle; oMin=8'hFF.
- CMP_CHECK_EN defined; force iCmp=3'b110 during a pending evaluation -> oErr=1 and stays 1, oTrend/oRunLen unchanged; next legal 3'b100 evaluation proceeds normally.

Source files
------------

// File: rtl/data_compare_tracker.sv
// Purpose: streaming trend tracker wrapped around an external 8-bit comparator.
// Latency: max/min/count 1 cycle after accept; trend/run 1 cycle after the pair is registered.
// Backpressure: none; every iValid edge is accepted, throughput one sample per clock.
//
// Ports:
//   iClk, iRst_n        clock, synchronous active-low reset
//   iValid, iSample     sample strobe and unsigned 8-bit sample
//   oCmp_a, oCmp_b      current / previous sample to the comparator
//   iCmp                comparator result {a>b, a==b, a<b}, combinational from oCmp_a/oCmp_b
//   oTrend, oRunLen     current trend (00 FLAT, 01 UP, 10 DOWN) and its run length
//   oRunDone            one-cycle pulse when a run ends
//   oMax, oMin, oCount  running max/min and saturating accepted-sample count
//   oErr                sticky illegal comparator code flag
//
// Optional feature macro: CMP_CHECK_EN (illegal iCmp detection; oErr tied low when undefined).
module data_compare_tracker #(
   parameter int RUN_W = 8,
   parameter int CNT_W = 16
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iValid,
   input  logic [7:0]       iSample,
   output logic [7:0]       oCmp_a,
   output logic [7:0]       oCmp_b,
   input  logic [2:0]       iCmp,
   output logic [1:0]       oTrend,
   output logic [RUN_W-1:0] oRunLen,
   output logic             oRunDone,
   output logic [7:0]       oMax,
   output logic [7:0]       oMin,
   output logic [CNT_W-1:0] oCount,
   output logic             oErr
);

   typedef enum logic [1:0] {EMPTY, FIRST, TRACK} state_t;

   localparam logic [1:0] FLAT = 2'b00;
   localparam logic [1:0] UP   = 2'b01;
   localparam logic [1:0] DOWN = 2'b10;

   state_t     state;
   logic       pend;      // a registered pair is waiting for its comparator result
   logic [1:0] dir;
   logic       evalOk;    // comparator code may update trend/run state

   // Anything that is not a clean a>b or a<b decodes as FLAT.
   always_comb begin
      dir = FLAT;
      if (iCmp == 3'b100)
         dir = UP;
      else if (iCmp == 3'b001)
         dir = DOWN;
   end

`ifdef CMP_CHECK_EN
   logic cmpLegal;
   assign cmpLegal = (iCmp == 3'b100) || (iCmp == 3'b010) || (iCmp == 3'b001);
   assign evalOk   = cmpLegal;

   always_ff @(posedge iClk) begin
      if (!iRst_n)
         oErr <= 1'b0;
      else if (pend && !cmpLegal)
         oErr <= 1'b1;
   end
`else
   assign evalOk = 1'b1;
   assign oErr   = 1'b0;
`endif

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state    <= EMPTY;
         pend     <= 1'b0;
         oCmp_a   <= 8'h00;
         oCmp_b   <= 8'h00;
         oTrend   <= FLAT;
         oRunLen  <= '0;
         oRunDone <= 1'b0;
         oMax     <= 8'h00;
         oMin     <= 8'hFF;
         oCount   <= '0;
      end else begin
         oRunDone <= 1'b0;

         // Evaluate the pair registered on the previous edge; iCmp still
         // reflects the pre-edge oCmp_a/oCmp_b even if a new sample shifts in now.
         if (pend && evalOk) begin
            if (dir == oTrend && oRunLen != '0) begin
               if (oRunLen != '1)
                  oRunLen <= oRunLen + RUN_W'(1);
            end else begin
               oTrend   <= dir;
               oRunLen  <= RUN_W'(1);
               // A zero run length means nothing was running yet, so no run ended.
               oRunDone <= (oRunLen != '0);
            end
         end

         if (iValid) begin
            if (oCount != '1)
               oCount <= oCount + CNT_W'(1);

            case (state)
               EMPTY: begin
                  // First sample seeds max/min directly instead of comparing
                  // against the reset values.
                  oCmp_a <= iSample;
                  oMax   <= iSample;
                  oMin   <= iSample;
                  state  <= FIRST;
               end
               default: begin
                  // FIRST and TRACK both shift the pair and track extremes.
                  oCmp_b <= oCmp_a;
                  oCmp_a <= iSample;
                  if (iSample > oMax)
                     oMax <= iSample;
                  if (iSample < oMin)
                     oMin <= iSample;
                  state  <= TRACK;
               end
            endcase
         end

         pend <= iValid && (state != EMPTY);
      end
   end

endmodule

// File: tb/tb_data_compare_tracker.sv
module tb_data_compare_tracker;

   logic        iClk = 1'b0;
   logic        iRst_n;
   logic        iValid;
   logic [7:0]  iSample;

   logic [7:0]  cmpA, cmpB, cmpA2, cmpB2;
   logic [2:0]  cmpRes, cmpRes2;
   logic        cmpForce;
   logic [2:0]  cmpForceVal;

   logic [1:0]  trend, trend2;
   logic [7:0]  runLen;
   logic [1:0]  runLen2;
   logic        runDone, runDone2;
   logic [7:0]  maxV, minV, maxV2, minV2;
   logic [15:0] count, count2;
   logic        err, err2;

   int nVec = 0;
   int nErr = 0;

   always #5 iClk = ~iClk;

   // Behavioural comparators closing the loop, with an override for illegal codes.
   assign cmpRes  = cmpForce ? cmpForceVal : {cmpA > cmpB, cmpA == cmpB, cmpA < cmpB};
   assign cmpRes2 = {cmpA2 > cmpB2, cmpA2 == cmpB2, cmpA2 < cmpB2};

   data_compare_tracker dut (
      .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .iSample(iSample),
      .oCmp_a(cmpA), .oCmp_b(cmpB), .iCmp(cmpRes),
      .oTrend(trend), .oRunLen(runLen), .oRunDone(runDone),
      .oMax(maxV), .oMin(minV), .oCount(count), .oErr(err)
   );

   data_compare_tracker #(.RUN_W(2)) dutNarrow (
      .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .iSample(iSample),
      .oCmp_a(cmpA2), .oCmp_b(cmpB2), .iCmp(cmpRes2),
      .oTrend(trend2), .oRunLen(runLen2), .oRunDone(runDone2),
      .oMax(maxV2), .oMin(minV2), .oCount(count2), .oErr(err2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; results are read at the next falling edge.
   task automatic step(input logic v, input logic [7:0] s);
      iValid  = v;
      iSample = s;
      @(negedge iClk);
   endtask

   task automatic doReset();
      iRst_n = 1'b0;
      step(1'b0, 8'h00);
      iRst_n = 1'b1;
   endtask

   initial begin
      iRst_n      = 1'b0;
      iValid      = 1'b0;
      iSample     = 8'h00;
      cmpForce    = 1'b0;
      cmpForceVal = 3'b000;
      @(negedge iClk);
      doReset();

      // Reset state
      chk("rst_cmpA", 32'(cmpA), 32'h00);
      chk("rst_cmpB", 32'(cmpB), 32'h00);
      chk("rst_trend", 32'(trend), 32'h0);
      chk("rst_runLen", 32'(runLen), 32'h0);
      chk("rst_runDone", 32'(runDone), 32'h0);
      chk("rst_max", 32'(maxV), 32'h00);
      chk("rst_min", 32'(minV), 32'hFF);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_err", 32'(err), 32'h0);

      // 10,20,30: two UP evaluations, no run ends
      step(1'b1, 8'd10);
      chk("t1_done_e1", 32'(runDone), 32'h0);
      step(1'b1, 8'd20);
      chk("t1_done_e2", 32'(runDone), 32'h0);
      step(1'b1, 8'd30);
      chk("t1_trend_e3", 32'(trend), 32'h1);
      chk("t1_runLen_e3", 32'(runLen), 32'h1);
      chk("t1_done_e3", 32'(runDone), 32'h0);
      step(1'b0, 8'd0);
      chk("t1_trend", 32'(trend), 32'h1);
      chk("t1_runLen", 32'(runLen), 32'h2);
      chk("t1_done_e4", 32'(runDone), 32'h0);
      chk("t1_max", 32'(maxV), 32'd30);
      chk("t1_min", 32'(minV), 32'd10);
      chk("t1_count", 32'(count), 32'd3);

      // 50,40,40,60: DOWN, FLAT, UP with two run-end pulses
      doReset();
      step(1'b1, 8'd50);
      step(1'b1, 8'd40);
      step(1'b1, 8'd40);
      chk("t2_trend_down", 32'(trend), 32'h2);
      chk("t2_len_down", 32'(runLen), 32'h1);
      chk("t2_done_down", 32'(runDone), 32'h0);
      step(1'b1, 8'd60);
      chk("t2_trend_flat", 32'(trend), 32'h0);
      chk("t2_len_flat", 32'(runLen), 32'h1);
      chk("t2_done_flat", 32'(runDone), 32'h1);
      step(1'b0, 8'd0);
      chk("t2_trend_up", 32'(trend), 32'h1);
      chk("t2_len_up", 32'(runLen), 32'h1);
      chk("t2_done_up", 32'(runDone), 32'h1);
      step(1'b0, 8'd0);
      chk("t2_done_idle", 32'(runDone), 32'h0);
      chk("t2_min", 32'(minV), 32'd40);
      chk("t2_max", 32'(maxV), 32'd60);
      chk("t2_count", 32'(count), 32'd4);

      // Single sample then idle: stays waiting for a second sample
      doReset();
      step(1'b1, 8'h80);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00);
      chk("t3_runLen", 32'(runLen), 32'h0);
      chk("t3_trend", 32'(trend), 32'h0);
      chk("t3_done", 32'(runDone), 32'h0);
      chk("t3_count", 32'(count), 32'd1);
      chk("t3_max", 32'(maxV), 32'h80);
      chk("t3_min", 32'(minV), 32'h80);
      chk("t3_cmpA", 32'(cmpA), 32'h80);
      chk("t3_cmpB", 32'(cmpB), 32'h00);

      // 1..6: 2-bit run length saturates at 3, 8-bit one reaches 5
      doReset();
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, 8'(i));
         chk("t4_done_narrow", 32'(runDone2), 32'h0);
      end
      step(1'b0, 8'd0);
      chk("t4_len_narrow", 32'(runLen2), 32'h3);
      chk("t4_trend_narrow", 32'(trend2), 32'h1);
      chk("t4_done_narrow_end", 32'(runDone2), 32'h0);
      chk("t4_len_wide", 32'(runLen), 32'h5);
      chk("t4_count_narrow", 32'(count2), 32'd6);

      // Reset right after a pair is registered: evaluation discarded
      doReset();
      step(1'b1, 8'd100);
      step(1'b1, 8'd50);
      iRst_n = 1'b0;
      step(1'b0, 8'd0);
      iRst_n = 1'b1;
      chk("t5_min", 32'(minV), 32'hFF);
      chk("t5_max", 32'(maxV), 32'h00);
      chk("t5_trend", 32'(trend), 32'h0);
      chk("t5_runLen", 32'(runLen), 32'h0);
      chk("t5_done", 32'(runDone), 32'h0);
      chk("t5_count", 32'(count), 32'h0);
      chk("t5_cmpA", 32'(cmpA), 32'h00);
      step(1'b0, 8'd0);
      chk("t5_runLen_after", 32'(runLen), 32'h0);
      chk("t5_done_after", 32'(runDone), 32'h0);

      // Illegal comparator code during a pending evaluation
      doReset();
      step(1'b1, 8'd10);
      step(1'b1, 8'd20);
      step(1'b1, 8'd30);
      chk("t6_trend_pre", 32'(trend), 32'h1);
      chk("t6_len_pre", 32'(runLen), 32'h1);
      cmpForce    = 1'b1;
      cmpForceVal = 3'b110;
      step(1'b0, 8'd0);
      cmpForce    = 1'b0;
`ifdef CMP_CHECK_EN
      chk("t6_err_set", 32'(err), 32'h1);
      chk("t6_trend_hold", 32'(trend), 32'h1);
      chk("t6_len_hold", 32'(runLen), 32'h1);
      chk("t6_done_bad", 32'(runDone), 32'h0);
`else
      chk("t6_err_tied", 32'(err), 32'h0);
      chk("t6_trend_flat", 32'(trend), 32'h0);
      chk("t6_len_flat", 32'(runLen), 32'h1);
      chk("t6_done_flat", 32'(runDone), 32'h1);
`endif
      step(1'b1, 8'd40);
      step(1'b0, 8'd0);
`ifdef CMP_CHECK_EN
      chk("t6_err_sticky", 32'(err), 32'h1);
      chk("t6_trend_next", 32'(trend), 32'h1);
      chk("t6_len_next", 32'(runLen), 32'h2);
      chk("t6_done_next", 32'(runDone), 32'h0);
`else
      chk("t6_err_tied_next", 32'(err), 32'h0);
      chk("t6_trend_next", 32'(trend), 32'h1);
      chk("t6_len_next", 32'(runLen), 32'h1);
      chk("t6_done_next", 32'(runDone), 32'h1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
